// File: rtl/snake_engine.sv
// snake_engine: snake body state, movement/collision rules and per-pixel cell query
module snake_engine #(
    parameter int MAX_LEN = 16,
    parameter int GRID_W = 40,
    parameter int GRID_H = 30,
    parameter int INIT_X = 20,
    parameter int INIT_Y = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       move_tick,
    input  logic [1:0] dir_in,
    input  logic       dir_valid,
    input  logic [5:0] apple_x,
    input  logic [4:0] apple_y,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    output logic [1:0] snake,
    output logic       apple_eaten,
    output logic       game_over,
    output logic [5:0] length,
    output logic [5:0] head_x,
    output logic [4:0] head_y
);
    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
    state_t state, state_nx;
    logic [5:0] seg_x [MAX_LEN];
    logic [4:0] seg_y [MAX_LEN];
    logic [1:0] cur_dir, pend_dir;
    logic [5:0] nh_x, cx;
    logic [4:0] nh_y;
    logic [5:0] cy;
    logic at_apple, grow, wall_hit, body_hit, collide, do_move, init, steer_ok;
    logic hit_head, hit_body, on_wall, off_screen;
    assign nh_x = pend_dir == 2'b10 ? seg_x[0] - 6'd1 : pend_dir == 2'b11 ? seg_x[0] + 6'd1 : seg_x[0];
    assign nh_y = pend_dir == 2'b00 ? seg_y[0] - 5'd1 : pend_dir == 2'b01 ? seg_y[0] + 5'd1 : seg_y[0];
    assign wall_hit = nh_x == 6'd0 || nh_x == 6'(GRID_W - 1) || nh_y == 5'd0 || nh_y == 5'(GRID_H - 1);
    assign at_apple = nh_x == apple_x && nh_y == apple_y;
    assign grow = at_apple && length < 6'(MAX_LEN);
    assign collide = wall_hit || body_hit;
    assign do_move = state == RUN && move_tick;
    assign init = state == DEAD && start;
    assign steer_ok = dir_valid && !(dir_in[1] == cur_dir[1] && dir_in[0] != cur_dir[0]);
    assign game_over = state == DEAD;
    assign head_x = seg_x[0];
    assign head_y = seg_y[0];
    // The tail cell is vacated by this move unless the snake grows, so it only blocks when growing.
    always_comb begin
        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++)
            if ((6'(i) < length - 6'd1 || (6'(i) == length - 6'd1 && grow)) && seg_x[i] == nh_x && seg_y[i] == nh_y)
                body_hit = 1'b1;
    end
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE && start ? RUN :
                   do_move && collide ? DEAD :
                   init ? IDLE : state;
    end
    always_ff @(posedge clk)
        state <= !rst ? IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (!rst || init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= 6'(INIT_X - i);
                seg_y[i] <= 5'(INIT_Y);
            end
            length <= 6'd3;
            cur_dir <= 2'b11;
            pend_dir <= 2'b11;
            apple_eaten <= 1'b0;
        end else begin
            apple_eaten <= do_move && !collide && at_apple;
            if (do_move && !collide) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nh_x;
                seg_y[0] <= nh_y;
                cur_dir <= pend_dir;
                if (grow)
                    length <= length + 6'd1;
            end
            if (steer_ok)
                pend_dir <= dir_in;
        end
    end
    assign cx = x_pos[9:4];
    assign cy = y_pos[9:4];
    assign off_screen = x_pos >= 10'(GRID_W * 16) || y_pos >= 10'(GRID_H * 16);
    assign on_wall = cx == 6'd0 || cx == 6'(GRID_W - 1) || cy == 6'd0 || cy == 6'(GRID_H - 1);
    assign hit_head = seg_x[0] == cx && {1'b0, seg_y[0]} == cy;
    always_comb begin
        hit_body = 1'b0;
        for (int i = 1; i < MAX_LEN; i++)
            if (6'(i) < length && seg_x[i] == cx && {1'b0, seg_y[i]} == cy)
                hit_body = 1'b1;
    end
    assign snake = off_screen ? 2'b00 : on_wall ? 2'b11 : hit_head ? 2'b01 : hit_body ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed and randomized checks of snake_engine against a queue-based game model
module tb_snake_engine;
    localparam int MAXL = 16;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, move_tick = 1'b0, dir_valid = 1'b0;
    logic [1:0] dir_in = 2'b00;
    logic [5:0] apple_x = 6'd1;
    logic [4:0] apple_y = 5'd1;
    logic [9:0] x_pos = 10'd0, y_pos = 10'd0;
    logic [1:0] snake;
    logic apple_eaten, game_over;
    logic [5:0] length, head_x;
    logic [4:0] head_y;
    int vecs = 0, errs = 0;
    bit chk_on = 0;
    int bx[$], by[$];
    int m_st, cd, pd, nx, ny, eats;
    bit m_eat, dead, eat, grw, acc;

    snake_engine #(.MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .start(start), .move_tick(move_tick), .dir_in(dir_in),
        .dir_valid(dir_valid), .apple_x(apple_x), .apple_y(apple_y), .x_pos(x_pos), .y_pos(y_pos),
        .snake(snake), .apple_eaten(apple_eaten), .game_over(game_over), .length(length),
        .head_x(head_x), .head_y(head_y)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, int act, int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic void m_init();
        bx = {20, 19, 18};
        by = {15, 15, 15};
        cd = 3;
        pd = 3;
        m_st = 0;
        m_eat = 0;
    endfunction

    function automatic int query(int x, int y);
        int qx = x / 16, qy = y / 16;
        if (x >= 640 || y >= 480) return 0;
        if (qx == 0 || qx == 39 || qy == 0 || qy == 29) return 3;
        if (bx[0] == qx && by[0] == qy) return 1;
        for (int i = 1; i < bx.size(); i++)
            if (bx[i] == qx && by[i] == qy) return 2;
        return 0;
    endfunction

    // Game rules at list level: head is bx[0]; moving pushes a new head and drops the tail unless growing.
    always @(posedge clk) begin
        if (!rst) m_init();
        else begin
            m_eat = 0;
            acc = dir_valid && !((int'(dir_in) ^ 1) == cd);
            if (m_st == 2 && start) m_init();
            else begin
                if (m_st == 0 && start) m_st = 1;
                else if (m_st == 1 && move_tick) begin
                    nx = bx[0] + (pd == 3 ? 1 : 0) - (pd == 2 ? 1 : 0);
                    ny = by[0] + (pd == 1 ? 1 : 0) - (pd == 0 ? 1 : 0);
                    dead = nx == 0 || nx == 39 || ny == 0 || ny == 29;
                    eat = nx == int'(apple_x) && ny == int'(apple_y);
                    grw = eat && bx.size() < MAXL;
                    for (int i = 1; i < bx.size(); i++)
                        if ((i < bx.size() - 1 || grw) && bx[i] == nx && by[i] == ny) dead = 1;
                    if (dead) m_st = 2;
                    else begin
                        bx.push_front(nx);
                        by.push_front(ny);
                        if (!grw) begin
                            void'(bx.pop_back());
                            void'(by.pop_back());
                        end
                        cd = pd;
                        m_eat = eat;
                    end
                end
                if (acc) pd = int'(dir_in);
            end
        end
    end

    always @(negedge clk) if (chk_on) begin
        chk("length", int'(length), bx.size());
        chk("head_x", int'(head_x), bx[0]);
        chk("head_y", int'(head_y), by[0]);
        chk("game_over", int'(game_over), m_st == 2 ? 1 : 0);
        chk("apple_eaten", int'(apple_eaten), int'(m_eat));
        chk("snake", int'(snake), query(int'(x_pos), int'(y_pos)));
    end

    task automatic rand_pix();
        int m = $urandom_range(0, 3), k, qx, qy;
        if (m == 0) begin
            x_pos = 10'($urandom_range(0, 1023));
            y_pos = 10'($urandom_range(0, 1023));
        end else begin
            k = m == 2 ? $urandom_range(0, bx.size() - 1) : 0;
            qx = m == 3 ? $urandom_range(0, 39) : bx[k];
            qy = m == 3 ? $urandom_range(0, 29) : by[k];
            x_pos = 10'(qx * 16 + $urandom_range(0, 15));
            y_pos = 10'(qy * 16 + $urandom_range(0, 15));
        end
    endtask

    task automatic cyc(bit s, bit mt, bit dv, logic [1:0] d);
        start = s;
        move_tick = mt;
        dir_valid = dv;
        dir_in = d;
        rand_pix();
        @(posedge clk);
        #1;
        start = 0;
        move_tick = 0;
        dir_valid = 0;
    endtask

    task automatic pix(string n, int x, int y, int exp);
        x_pos = 10'(x);
        y_pos = 10'(y);
        #1;
        chk(n, int'(snake), exp);
    endtask

    task automatic do_reset();
        rst = 0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst = 1;
    endtask

    task automatic apple_ahead();
        apple_x = 6'(bx[0] + (pd == 3 ? 1 : 0) - (pd == 2 ? 1 : 0));
        apple_y = 5'(by[0] + (pd == 1 ? 1 : 0) - (pd == 0 ? 1 : 0));
    endtask

    initial begin
        rst = 0;
        cyc(0, 0, 0, 0);
        chk_on = 1;
        do_reset();
        chk("rst_len", int'(length), 3);
        chk("rst_hx", int'(head_x), 20);
        chk("rst_hy", int'(head_y), 15);
        chk("rst_go", int'(game_over), 0);
        pix("pix_head", 320, 240, 1);
        pix("pix_body", 304, 240, 2);
        pix("pix_wall", 0, 0, 3);
        pix("pix_off", 700, 240, 0);
        cyc(0, 1, 0, 0);
        chk("idle_tick", int'(head_x), 20);
        // steering: reverse request rejected, then turn up
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 2'b10);
        cyc(0, 1, 0, 0);
        chk("steer_rev", int'(head_x), 21);
        cyc(0, 0, 1, 2'b00);
        cyc(0, 1, 0, 0);
        chk("steer_up_x", int'(head_x), 21);
        chk("steer_up_y", int'(head_y), 14);
        pix("steer_b1", 21 * 16 + 3, 15 * 16 + 9, 2);
        pix("steer_b2", 20 * 16, 15 * 16, 2);
        // growth
        do_reset();
        apple_x = 6'd22;
        apple_y = 5'd15;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("grow_pre", int'(apple_eaten), 0);
        cyc(0, 1, 0, 0);
        chk("grow_eat", int'(apple_eaten), 1);
        chk("grow_len", int'(length), 4);
        chk("grow_hx", int'(head_x), 22);
        apple_x = 6'd1;
        apple_y = 5'd1;
        cyc(0, 0, 0, 0);
        chk("grow_pulse", int'(apple_eaten), 0);
        cyc(0, 1, 0, 0);
        pix("grow_tail", 20 * 16, 15 * 16, 2);
        pix("grow_gone", 19 * 16, 15 * 16, 0);
        // wall death
        do_reset();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 18; i++) cyc(0, 1, 0, 0);
        chk("wall_hx", int'(head_x), 38);
        chk("wall_alive", int'(game_over), 0);
        cyc(0, 1, 0, 0);
        chk("wall_dead", int'(game_over), 1);
        chk("wall_frozen", int'(head_x), 38);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 2'b00);
        cyc(0, 1, 0, 0);
        chk("dead_ignore", int'(head_x), 38);
        cyc(1, 0, 0, 0);
        chk("reinit_go", int'(game_over), 0);
        chk("reinit_len", int'(length), 3);
        chk("reinit_hx", int'(head_x), 20);
        cyc(0, 1, 0, 0);
        chk("reinit_idle", int'(head_x), 20);
        // self collision
        do_reset();
        cyc(1, 0, 0, 0);
        apple_x = 6'd21;
        apple_y = 5'd15;
        cyc(0, 1, 0, 0);
        apple_x = 6'd22;
        cyc(0, 1, 0, 0);
        apple_x = 6'd1;
        apple_y = 5'd1;
        chk("self_len", int'(length), 5);
        cyc(0, 0, 1, 2'b00);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 2'b10);
        cyc(0, 1, 0, 0);
        chk("self_alive", int'(game_over), 0);
        cyc(0, 0, 1, 2'b01);
        cyc(0, 1, 0, 0);
        chk("self_dead", int'(game_over), 1);
        chk("self_hy", int'(head_y), 14);
        // saturation then mid-game reset
        do_reset();
        cyc(1, 0, 0, 0);
        eats = 0;
        for (int i = 0; i < 15; i++) begin
            apple_ahead();
            cyc(0, 1, 0, 0);
            eats += int'(apple_eaten);
        end
        chk("sat_len", int'(length), MAXL);
        chk("sat_eats", eats, 15);
        chk("sat_hx", int'(head_x), 35);
        rst = 0;
        cyc(0, 1, 0, 0);
        rst = 1;
        chk("mid_len", int'(length), 3);
        chk("mid_hx", int'(head_x), 20);
        chk("mid_eat", int'(apple_eaten), 0);
        cyc(0, 1, 0, 0);
        chk("mid_idle", int'(head_x), 20);
        // randomized play
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 2) == 0) apple_ahead();
            else if ($urandom_range(0, 7) == 0) begin
                apple_x = 6'($urandom_range(0, 39));
                apple_y = 5'($urandom_range(0, 29));
            end
            rst = $urandom_range(0, 399) != 0;
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
        end
        rst = 1;
        cyc(0, 0, 0, 0);
        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
- Game-state core upstream of the VGA colour stage.
- Holds the snake body as a list of grid cells on a 40x30 board of 16x16-pixel cells.
- Advances the snake one cell per move_tick, applies steering, growth and collision rules.
- Answers the per-pixel query "what occupies the cell under (x_pos, y_pos)" with a 2-bit code, which the VGA stage consumes directly as its `snake` input.

Parameters:
- MAX_LEN, 16, maximum body segments including head (2..32)
- GRID_W, 40, board width in cells
- GRID_H, 30, board height in cells
- INIT_X, 20, initial head column
- INIT_Y, 15, initial head row

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst  in  1  synchronous, active-low reset; sampled on clk rising edge, 0 = reset
- start  in  1  one-cycle pulse: begin game (IDLE) or reinitialise (DEAD)
- move_tick  in  1  one-cycle pulse: advance snake one cell
- dir_in  in  2  requested direction: 00 up, 01 down, 10 left, 11 right
- dir_valid  in  1  qualifies dir_in for one cycle
- apple_x  in  6  apple column
- apple_y  in  5  apple row
- x_pos  in  10  current scan pixel x
- y_pos  in  10  current scan pixel y
- snake  out  2  cell code at (x_pos, y_pos): 00 none, 01 head, 10 body, 11 wall
- apple_eaten  out  1  one-cycle pulse when head enters the apple cell
- game_over  out  1  high while in DEAD
- length  out  6  current segment count
- head_x  out  6  head column
- head_y  out  5  head row

Behaviour:
- Reset (rst==0 at clk edge) forces the following, with no partial state surviving. This also applies mid-move.
  - state IDLE; length=3.
  - seg0=(INIT_X,INIT_Y), seg1=(INIT_X-1,INIT_Y), seg2=(INIT_X-2,INIT_Y).
  - cur_dir=pend_dir=right.
  - apple_eaten=0, game_over=0.
- States: IDLE, RUN, DEAD.
  - IDLE: body shown, no motion. start -> RUN next cycle.
  - RUN: move_tick triggers one move, completed in the same edge; results visible the next cycle. start is ignored in RUN.
  - DEAD: game_over=1, body frozen. start -> reinitialise body to reset values and enter IDLE.
- Steering: on dir_valid, pend_dir<=dir_in unless dir_in is the reverse of cur_dir (same bit1, different bit0); reverse requests are discarded. Later requests before a tick overwrite earlier ones. On move, cur_dir<=pend_dir.
- Move computation uses pend_dir as effective direction, giving next head nh.
  - Collision if nh is in column 0 or GRID_W-1, or in row 0 or GRID_H-1.
  - Collision if nh equals any seg1..seg(length-1); the tail seg(length-1) is excluded unless growing this move.
  - Growing = (nh == (apple_x, apple_y)) and length<MAX_LEN.
- Collision -> DEAD, body unchanged, no apple_eaten.
- Otherwise, shift seg[i]<=seg[i-1] for i=1..MAX_LEN-1 and seg0<=nh.
  - If nh equals the apple: apple_eaten=1 for exactly one cycle, and length<=length+1, saturating at MAX_LEN. At saturation the snake moves without growing but apple_eaten still pulses.
- move_tick outside RUN is ignored. move_tick coincident with dir_valid: the move uses the pend_dir held before that edge; the new request applies to the next move.
- Pixel query is combinational from x_pos, y_pos and registered state, zero latency.
  - cell=(x_pos[9:4], y_pos[9:4]).
  - If x_pos>=640 or y_pos>=480 -> 00.
  - Else priority: wall (border cell) 11 > seg0 01 > any seg1..seg(length-1) 10 > 00.
  - Segments at index >= length never match.
- head_x/head_y = seg0; length registered.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> length=3, head=(20,15), game_over=0. Query x_pos=320,y_pos=240 -> snake=01; x_pos=304,y_pos=240 -> 10; x_pos=0,y_pos=0 -> 11; x_pos=700 -> 00.
- Steering: start, then dir_in=10 (left) with dir_valid, then tick -> rejected, head=(21,15). Then dir_in=00 (up) + tick -> head=(21,14); body at (21,15) and (20,15).
- Growth: apple=(22,15), start, 2 ticks -> second tick gives apple_eaten pulse of 1 cycle, length=4, head=(22,15). Next tick, tail stays at (20,15)->(21,15) order preserved.
- Wall death: start, 18 right ticks -> head=(38,15). 19th tick -> game_over=1, head unchanged, further ticks ignored. start -> IDLE, length=3, head=(20,15).
- Self collision: grow to length 5, then steer up, left, down in consecutive ticks -> DEAD on the down move.
- Saturation and mid-game reset: with MAX_LEN=4, eat 2 apples -> length stays 4, apple_eaten pulses twice. Assert rst=0 mid-RUN -> next cycle state IDLE, all outputs at reset values.
